note_lane_tracker: RTL

Per-lane note state keeper for the Guitar Hero display and scoring path. It holds up to NUM_SLOTS falling notes and advances their vertical positions once per video frame. It resolves player hit requests against a hit window, and keeps score and streak counters. Its packed per-slot y positions and valid mask feed the per-note screen-bounds checkers downstream, one checker per slot.

---
 rtl/note_lane_tracker_if.sv | 26 ++
 rtl/note_lane_tracker.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/note_lane_tracker_if.sv
// rtl/note_lane_tracker_if.sv - lane event inputs and note state outputs of one note lane
interface note_lane_tracker_if #(
    parameter int NUM_SLOTS = 8
);
    logic                     frame_tick;
    logic                     spawn;
    logic                     hit;
    logic [32*NUM_SLOTS-1:0]  note_y_flat;
    logic [NUM_SLOTS-1:0]     note_valid;
    logic                     hit_ok;
    logic                     hit_bad;
    logic                     miss;
    logic                     spawn_drop;
    logic [15:0]              score;
    logic [7:0]               streak;

    modport master (
        output frame_tick, spawn, hit,
        input  note_y_flat, note_valid, hit_ok, hit_bad, miss, spawn_drop, score, streak
    );

    modport slave (
        input  frame_tick, spawn, hit,
        output note_y_flat, note_valid, hit_ok, hit_bad, miss, spawn_drop, score, streak
    );
endinterface

// File: rtl/note_lane_tracker.sv
// rtl/note_lane_tracker.sv - per-lane falling note slots, hit resolution, score and streak
module note_lane_tracker #(
    parameter int NUM_SLOTS = 8,
    parameter int SPEED     = 2,
    parameter int SPAWN_Y   = 0,
    parameter int BOTTOM_Y  = 480,
    parameter int HIT_LO    = 400,
    parameter int HIT_HI    = 440
) (
    input  logic                clock,
    input  logic                reset,
    note_lane_tracker_if.slave  bus
);
    localparam logic [10:0] L_SPEED  = 11'(SPEED);
    localparam logic [10:0] L_BOTTOM = 11'(BOTTOM_Y);
    localparam logic [10:0] L_HIT_LO = 11'(HIT_LO);
    localparam logic [10:0] L_HIT_HI = 11'(HIT_HI);
    localparam logic [9:0]  L_SPAWN  = 10'(SPAWN_Y);

    logic [9:0]           r_y [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] r_valid;
    logic [15:0]          r_score;
    logic [7:0]           r_streak;
    logic                 r_hit_ok;
    logic                 r_hit_bad;
    logic                 r_miss;
    logic                 r_spawn_drop;

    logic [9:0]           w_y_nxt [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_valid_nxt;
    logic [NUM_SLOTS-1:0] w_hit_mask;
    logic [NUM_SLOTS-1:0] w_free_mask;
    logic [10:0]          w_sum [NUM_SLOTS];
    logic [9:0]           w_best_y;
    logic                 w_found;
    logic                 w_free_found;
    logic                 w_hit_ok;
    logic                 w_hit_bad;
    logic                 w_retire;

    // All three stages look only at start-of-cycle r_valid/r_y; a slot freed
    // by a hit or retirement is never the spawn target in the same cycle.
    always_comb begin
        w_found      = 1'b0;
        w_best_y     = '0;
        w_hit_mask   = '0;
        w_free_found = 1'b0;
        w_free_mask  = '0;
        w_retire     = 1'b0;
        w_valid_nxt  = r_valid;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_y_nxt[i] = r_y[i];
            w_sum[i]   = {1'b0, r_y[i]} + L_SPEED;
        end

        // Strict '>' while scanning upward keeps ties on the lowest index.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_valid[i] && ({1'b0, r_y[i]} >= L_HIT_LO) && ({1'b0, r_y[i]} <= L_HIT_HI)
                && (!w_found || (r_y[i] > w_best_y))) begin
                w_found       = 1'b1;
                w_best_y      = r_y[i];
                w_hit_mask    = '0;
                w_hit_mask[i] = 1'b1;
            end
            if (!r_valid[i] && !w_free_found) begin
                w_free_found   = 1'b1;
                w_free_mask[i] = 1'b1;
            end
        end

        w_hit_ok  = bus.hit && w_found;
        w_hit_bad = bus.hit && !w_found;
        if (w_hit_ok) begin
            w_valid_nxt = r_valid & ~w_hit_mask;
        end

        if (bus.frame_tick) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (r_valid[i] && !(w_hit_ok && w_hit_mask[i])) begin
                    if (w_sum[i] >= L_BOTTOM) begin
                        w_valid_nxt[i] = 1'b0;
                        w_retire       = 1'b1;
                    end else begin
                        w_y_nxt[i] = w_sum[i][9:0];
                    end
                end
            end
        end

        if (bus.spawn && w_free_found) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_free_mask[i]) begin
                    w_valid_nxt[i] = 1'b1;
                    w_y_nxt[i]     = L_SPAWN;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_y[i] <= '0;
            end
            r_valid      <= '0;
            r_score      <= '0;
            r_streak     <= '0;
            r_hit_ok     <= 1'b0;
            r_hit_bad    <= 1'b0;
            r_miss       <= 1'b0;
            r_spawn_drop <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_y[i] <= w_y_nxt[i];
            end
            r_valid      <= w_valid_nxt;
            r_hit_ok     <= w_hit_ok;
            r_hit_bad    <= w_hit_bad;
            r_miss       <= w_retire;
            r_spawn_drop <= bus.spawn && !w_free_found;
            if (w_hit_ok && (r_score != 16'hFFFF)) begin
                r_score <= r_score + 16'd1;
            end
            // A miss or bad hit zeroes the streak even alongside a good hit.
            if (w_hit_bad || w_retire) begin
                r_streak <= '0;
            end else if (w_hit_ok && (r_streak != 8'hFF)) begin
                r_streak <= r_streak + 8'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
        assign bus.note_y_flat[32*g +: 32] = {22'd0, r_y[g]};
    end

    assign bus.note_valid = r_valid;
    assign bus.hit_ok     = r_hit_ok;
    assign bus.hit_bad    = r_hit_bad;
    assign bus.miss       = r_miss;
    assign bus.spawn_drop = r_spawn_drop;
    assign bus.score      = r_score;
    assign bus.streak     = r_streak;
endmodule
